// File: rtl/bit_4_sub_pkg.sv
// -----------------------------------------------------------------------------
// bit_4_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   state_t        - sequencer states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  - default operand/result width
//   cnt_width()    - width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package bit_4_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    // Guard against a zero-width counter for degenerate widths.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_nand.sv
// -----------------------------------------------------------------------------
// full_subtractor_nand
// One-bit full subtractor built exclusively from 2-input NAND cells.
//   x    in  1  minuend bit
//   y    in  1  subtrahend bit
//   bin  in  1  borrow in
//   d    out 1  difference  = x ^ y ^ bin
//   bout out 1  borrow out  = (~x & y) | (~(x ^ y) & bin)
// Also contains nand2_cell, the single primitive the subtractor is made of.
// -----------------------------------------------------------------------------
module nand2_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module full_subtractor_nand (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic n1, n2, n3, p;
    logic m1, m2, m3;

    // First XOR stage: p = x ^ y. As a by-product n3 = ~(~x & y).
    nand2_cell u_n1 (.a(x),  .b(y),  .y(n1));
    nand2_cell u_n2 (.a(x),  .b(n1), .y(n2));
    nand2_cell u_n3 (.a(y),  .b(n1), .y(n3));
    nand2_cell u_p  (.a(n2), .b(n3), .y(p));

    // Second XOR stage: d = p ^ bin. As a by-product m3 = ~(~p & bin).
    nand2_cell u_m1 (.a(p),   .b(bin), .y(m1));
    nand2_cell u_m2 (.a(p),   .b(m1),  .y(m2));
    nand2_cell u_m3 (.a(bin), .b(m1),  .y(m3));
    nand2_cell u_d  (.a(m2),  .b(m3),  .y(d));

    // The two XOR by-products are exactly the inverted borrow terms,
    // so one more NAND ORs them together.
    nand2_cell u_bo (.a(n3), .b(m3), .y(bout));

endmodule

// File: rtl/bit_4_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bit_4_serial_subtractor
// Bit-serial subtractor computing A - B - Bin over WIDTH cycles, LSB first,
// with a single NAND full-subtractor cell.
//   clk      in  1      rising-edge clock
//   rst      in  1      asynchronous active-high reset
//   start    in  1      request, sampled only in IDLE
//   a_in     in  WIDTH  minuend
//   b_in     in  WIDTH  subtrahend
//   bin_in   in  1      borrow in
//   busy     out 1      high from accepted start until back in IDLE
//   done     out 1      one-cycle result-valid pulse
//   diff_out out WIDTH  registered difference, held until next done
//   bout_out out 1      registered borrow out (unsigned underflow)
//   ovf_out  out 1      signed overflow
// Build option: define SUB_OVERFLOW_EN to build the overflow flag; otherwise
// ovf_out is tied low.
// -----------------------------------------------------------------------------
module bit_4_serial_subtractor
    import bit_4_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             bout_out,
    output logic             ovf_out
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             borrow_reg;
    logic [CW-1:0]    cnt_reg;
    logic             cell_d, cell_bout;
    logic             last_bit;

    assign last_bit = (cnt_reg == LAST);

    full_subtractor_nand u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // busy/done decode straight from the state register, so they drop
    // the instant reset asserts.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            diff_out   <= '0;
            bout_out   <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sr       <= a_in;
                        b_sr       <= b_in;
                        borrow_reg <= bin_in;
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr       <= a_sr >> 1;
                    b_sr       <= b_sr >> 1;
                    // Difference bits enter at the MSB and walk toward bit 0,
                    // so after WIDTH shifts the first bit computed sits at LSB.
                    res_sr     <= {cell_d, res_sr[WIDTH-1:1]};
                    borrow_reg <= cell_bout;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        diff_out <= {cell_d, res_sr[WIDTH-1:1]};
                        bout_out <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_OVERFLOW_EN
    // On the last bit the cell inputs are the operand MSBs and cell_d is the
    // result MSB, so no extra capture of the sign bits is needed.
    logic ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == SHIFT && last_bit) begin
            ovf_reg <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
        end
    end

    assign ovf_out = ovf_reg;
`else
    assign ovf_out = 1'b0;
`endif

endmodule

// File: tb/tb_bit_4_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_bit_4_serial_subtractor
// Self-checking bench: directed test-plan vectors, randomized operations,
// back-to-back starts with start held high, and reset mid-operation.
// Expected results come from integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_bit_4_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         bin_in;
    logic         busy, done, bout_out, ovf_out;
    logic [W-1:0] diff_out;

    int checks   = 0;
    int failures = 0;

    // Observations from the most recent do_op call.
    int           obs_lat, obs_done_cnt, obs_busy_cnt;
    logic [W-1:0] obs_diff, held_diff;
    logic         obs_bout, obs_ovf, held_bout;

    bit_4_serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .diff_out (diff_out),
        .bout_out (bout_out),
        .ovf_out  (ovf_out)
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction, unsigned and signed views.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bin, output logic [W-1:0] d,
                                  output logic bo, output logic ov);
        int ua, ub, r, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        r  = ua - ub - int'(bin);
        d  = r[W-1:0];
        bo = (ua < ub + int'(bin));
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = sa - sb - int'(bin);
        ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
`ifndef SUB_OVERFLOW_EN
        ov = 1'b0;
`endif
    endfunction

    // Launch one operation and record what the DUT shows; no checking here.
    // Cycle k counts negedges after the start edge (k=0 is the first one).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        a_in = a; b_in = b; bin_in = bin; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        bin_in = 1'($urandom);
        obs_lat = -1; obs_done_cnt = 0; obs_busy_cnt = 0;
        obs_diff = '0; obs_bout = 1'b0; obs_ovf = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (busy) obs_busy_cnt++;
            if (done) begin
                obs_done_cnt++;
                if (obs_lat < 0) begin
                    obs_lat  = k;
                    obs_diff = diff_out;
                    obs_bout = bout_out;
                    obs_ovf  = ovf_out;
                end
            end
        end
        held_diff = diff_out;
        held_bout = bout_out;
        $display("op a=%b b=%b bin=%b -> diff=%b bout=%b ovf=%b lat=%0d dones=%0d busy=%0d",
                 a, b, bin, obs_diff, obs_bout, obs_ovf, obs_lat, obs_done_cnt, obs_busy_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; bin_in = 1'b0;
        #3;
        checks++;
        if ({busy, done, diff_out, bout_out, ovf_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
                     busy, done, diff_out, bout_out, ovf_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic bin);
        logic [W-1:0] ed;
        logic eb, eo;
        model(a, b, bin, ed, eb, eo);
        do_op(a, b, bin);
        checks++;
        if (obs_lat !== W) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", name, obs_lat, W);
        end
        checks++;
        if (obs_done_cnt !== 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d want 1", name, obs_done_cnt);
        end
        checks++;
        if (obs_busy_cnt !== W + 1) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, obs_busy_cnt, W + 1);
        end
        checks++;
        if (obs_diff !== ed || obs_bout !== eb || obs_ovf !== eo) begin
            failures++;
            $display("FAIL %s result: got diff=%b bout=%b ovf=%b want diff=%b bout=%b ovf=%b",
                     name, obs_diff, obs_bout, obs_ovf, ed, eb, eo);
        end
        checks++;
        if (held_diff !== ed || held_bout !== eb) begin
            failures++;
            $display("FAIL %s held: got diff=%b bout=%b want diff=%b bout=%b",
                     name, held_diff, held_bout, ed, eb);
        end
    endtask

    task automatic test_directed();
        check_op("plan_1011_0111", 4'b1011, 4'b0111, 1'b0);
        check_op("plan_0011_0101", 4'b0011, 4'b0101, 1'b0);
        check_op("plan_0000_0000_b1", 4'b0000, 4'b0000, 1'b1);
        check_op("plan_1000_0001", 4'b1000, 4'b0001, 1'b0);
        check_op("plan_0111_1111", 4'b0111, 4'b1111, 1'b0);
        check_op("edge_1000_0000_b1", 4'b1000, 4'b0000, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_op($sformatf("rand_%0d", i), W'($urandom), W'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ops_a [0:3*W+8];
        logic [W-1:0] ops_b [0:3*W+8];
        logic         ops_c [0:3*W+8];
        logic [W-1:0] ed0, ed1;
        logic         eb0, eb1, eo0, eo1;
        int           dones, edge0, edge1, waited;
        logic [W-1:0] d0, d1;
        logic         b0, b1, busy_gap;

        dones = 0; edge0 = -1; edge1 = -1; d0 = '0; d1 = '0; b0 = 0; b1 = 0; busy_gap = 1'b1;
        @(negedge clk);
        start = 1'b1;
        ops_a[0] = W'($urandom); ops_b[0] = W'($urandom); ops_c[0] = 1'($urandom);
        a_in = ops_a[0]; b_in = ops_b[0]; bin_in = ops_c[0];
        for (int c = 0; c <= 2 * W + 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == W + 1) busy_gap = busy;
            if (done) begin
                dones++;
                if (dones == 1) begin edge0 = c; d0 = diff_out; b0 = bout_out; end
                if (dones == 2) begin edge1 = c; d1 = diff_out; b1 = bout_out; end
            end
            ops_a[c+1] = W'($urandom); ops_b[c+1] = W'($urandom); ops_c[c+1] = 1'($urandom);
            a_in = ops_a[c+1]; b_in = ops_b[c+1]; bin_in = ops_c[c+1];
        end
        start = 1'b0;
        waited = 0;
        while (busy === 1'b1 && waited < W + 4) begin
            @(negedge clk);
            waited++;
        end
        model(ops_a[0], ops_b[0], ops_c[0], ed0, eb0, eo0);
        model(ops_a[W+2], ops_b[W+2], ops_c[W+2], ed1, eb1, eo1);
        $display("b2b op0 a=%b b=%b bin=%b -> diff=%b bout=%b at cycle %0d",
                 ops_a[0], ops_b[0], ops_c[0], d0, b0, edge0);
        $display("b2b op1 a=%b b=%b bin=%b -> diff=%b bout=%b at cycle %0d",
                 ops_a[W+2], ops_b[W+2], ops_c[W+2], d1, b1, edge1);
        checks++;
        if (dones !== 2) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d want 2", dones);
        end
        checks++;
        if (edge0 !== W || edge1 !== 2 * W + 2) begin
            failures++;
            $display("FAIL b2b_done_edges: got %0d,%0d want %0d,%0d", edge0, edge1, W, 2 * W + 2);
        end
        checks++;
        if (d0 !== ed0 || b0 !== eb0) begin
            failures++;
            $display("FAIL b2b_op0_result: got diff=%b bout=%b want diff=%b bout=%b", d0, b0, ed0, eb0);
        end
        checks++;
        if (d1 !== ed1 || b1 !== eb1) begin
            failures++;
            $display("FAIL b2b_op1_result: got diff=%b bout=%b want diff=%b bout=%b", d1, b1, ed1, eb1);
        end
        checks++;
        if (busy_gap !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_gap: got busy=%b want 0", busy_gap);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain_timeout: busy still %b after %0d cycles", busy, waited);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones_seen, busy_seen;
        @(negedge clk);
        a_in = 4'b1010; b_in = 4'b0011; bin_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        $display("reset mid-op -> busy=%b done=%b diff=%b bout=%b ovf=%b",
                 busy, done, diff_out, bout_out, ovf_out);
        checks++;
        if ({busy, done, diff_out, bout_out, ovf_out} !== '0) begin
            failures++;
            $display("FAIL midop_reset_outputs: got busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
                     busy, done, diff_out, bout_out, ovf_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones_seen = 0; busy_seen = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            if (done) dones_seen++;
            if (busy) busy_seen++;
        end
        checks++;
        if (dones_seen !== 0 || busy_seen !== 0) begin
            failures++;
            $display("FAIL midop_aborted: got dones=%0d busy_cycles=%0d want 0 0", dones_seen, busy_seen);
        end
        do_op(4'b1111, 4'b0001, 1'b0);
        checks++;
        if (obs_done_cnt !== 1 || obs_diff !== 4'b1110 || obs_bout !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_op: got dones=%0d diff=%b bout=%b want 1 1110 0",
                     obs_done_cnt, obs_diff, obs_bout);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
